// File: rtl/fu_result_arbiter.sv
// fu_result_arbiter: shares one CDB broadcast port and one ROB write port
// among N functional units. Each channel runs its own round-robin pointer,
// issues a combinational one-hot grant and registers the winner's payload
// onto its bus one cycle later.
module fu_result_arbiter #(
    parameter int N      = 4,
    parameter int ID_W   = 4,
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          cdb_req,
    input  logic [N*ID_W-1:0]     cdb_req_id,
    input  logic [N*DATA_W-1:0]   cdb_req_val,
    output logic [N-1:0]          cdb_grant,
    input  logic [N-1:0]          rob_req,
    input  logic [N*ID_W-1:0]     rob_req_id,
    input  logic [N*DATA_W-1:0]   rob_req_flags,
    input  logic [N*DATA_W-1:0]   rob_req_wbs,
    input  logic [N*DATA_W-1:0]   rob_req_val,
    output logic [N-1:0]          rob_grant,
    input  logic                  rob_ready,
    input  logic                  flush,
    output logic                  cdb_valid,
    output logic [ID_W-1:0]       cdb_id,
    output logic [DATA_W-1:0]     cdb_val,
    output logic                  rob_valid,
    output logic [ID_W-1:0]       rob_id,
    output logic [DATA_W-1:0]     rob_flags,
    output logic [DATA_W-1:0]     rob_wbs,
    output logic [DATA_W-1:0]     rob_val
);

    localparam int PTR_W = $clog2(N);

    // Per-FU payload views of the flattened input buses.
    logic [ID_W-1:0]   cdb_id_arr    [N];
    logic [DATA_W-1:0] cdb_val_arr   [N];
    logic [ID_W-1:0]   rob_id_arr    [N];
    logic [DATA_W-1:0] rob_flags_arr [N];
    logic [DATA_W-1:0] rob_wbs_arr   [N];
    logic [DATA_W-1:0] rob_val_arr   [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
        assign cdb_id_arr[gi]    = cdb_req_id[gi*ID_W +: ID_W];
        assign cdb_val_arr[gi]   = cdb_req_val[gi*DATA_W +: DATA_W];
        assign rob_id_arr[gi]    = rob_req_id[gi*ID_W +: ID_W];
        assign rob_flags_arr[gi] = rob_req_flags[gi*DATA_W +: DATA_W];
        assign rob_wbs_arr[gi]   = rob_req_wbs[gi*DATA_W +: DATA_W];
        assign rob_val_arr[gi]   = rob_req_val[gi*DATA_W +: DATA_W];
    end

    // Round-robin scan: first requester at or above ptr, wrapping N-1 -> 0.
    // Returns {found, index}.
    function automatic logic [PTR_W:0] rr_pick(input logic [N-1:0] req,
                                               input logic [PTR_W-1:0] ptr);
        logic             found;
        logic [PTR_W-1:0] win;
        logic [PTR_W:0]   cand;
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, ptr} + (PTR_W+1)'(k);
            if (cand >= (PTR_W+1)'(N)) begin
                cand = cand - (PTR_W+1)'(N);
            end
            if (!found && req[cand[PTR_W-1:0]]) begin
                found = 1'b1;
                win   = cand[PTR_W-1:0];
            end
        end
        return {found, win};
    endfunction

    // Pointer moves to the slot just past the winner.
    function automatic logic [PTR_W-1:0] ptr_after(input logic [PTR_W-1:0] win);
        return (win == PTR_W'(N-1)) ? '0 : win + 1'b1;
    endfunction

    logic [PTR_W-1:0]  cdb_ptr_q, cdb_ptr_d;
    logic [PTR_W-1:0]  rob_ptr_q, rob_ptr_d;
    logic              cdb_valid_q, cdb_valid_d;
    logic [ID_W-1:0]   cdb_id_q, cdb_id_d;
    logic [DATA_W-1:0] cdb_val_q, cdb_val_d;
    logic              rob_valid_q, rob_valid_d;
    logic [ID_W-1:0]   rob_id_q, rob_id_d;
    logic [DATA_W-1:0] rob_flags_q, rob_flags_d;
    logic [DATA_W-1:0] rob_wbs_q, rob_wbs_d;
    logic [DATA_W-1:0] rob_val_q, rob_val_d;

    logic [PTR_W:0]    cdb_pick, rob_pick;
    logic [PTR_W-1:0]  cdb_win, rob_win;
    logic              cdb_fire, rob_fire;

    assign cdb_pick = rr_pick(cdb_req, cdb_ptr_q);
    assign rob_pick = rr_pick(rob_req, rob_ptr_q);
    assign cdb_win  = cdb_pick[PTR_W-1:0];
    assign rob_win  = rob_pick[PTR_W-1:0];

    // Flush kills both channels; ROB additionally waits for rob_ready.
    // Grants are forced low while reset is held.
    assign cdb_fire = cdb_pick[PTR_W] && !flush && !rst;
    assign rob_fire = rob_pick[PTR_W] && !flush && rob_ready && !rst;

    for (genvar gi = 0; gi < N; gi++) begin : g_grant
        assign cdb_grant[gi] = cdb_fire && (cdb_win == PTR_W'(gi));
        assign rob_grant[gi] = rob_fire && (rob_win == PTR_W'(gi));
    end

    // CDB next state: capture winner and advance pointer, else hold payload.
    always_comb begin
        cdb_valid_d = cdb_fire;
        cdb_id_d    = cdb_id_q;
        cdb_val_d   = cdb_val_q;
        cdb_ptr_d   = cdb_ptr_q;
        if (cdb_fire) begin
            cdb_id_d  = cdb_id_arr[cdb_win];
            cdb_val_d = cdb_val_arr[cdb_win];
            cdb_ptr_d = ptr_after(cdb_win);
        end
    end

    // ROB next state: same policy as the CDB channel with a wider payload.
    always_comb begin
        rob_valid_d = rob_fire;
        rob_id_d    = rob_id_q;
        rob_flags_d = rob_flags_q;
        rob_wbs_d   = rob_wbs_q;
        rob_val_d   = rob_val_q;
        rob_ptr_d   = rob_ptr_q;
        if (rob_fire) begin
            rob_id_d    = rob_id_arr[rob_win];
            rob_flags_d = rob_flags_arr[rob_win];
            rob_wbs_d   = rob_wbs_arr[rob_win];
            rob_val_d   = rob_val_arr[rob_win];
            rob_ptr_d   = ptr_after(rob_win);
        end
    end

    // Bus and pointer registers for both channels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cdb_ptr_q   <= '0;
            cdb_valid_q <= 1'b0;
            cdb_id_q    <= '0;
            cdb_val_q   <= '0;
            rob_ptr_q   <= '0;
            rob_valid_q <= 1'b0;
            rob_id_q    <= '0;
            rob_flags_q <= '0;
            rob_wbs_q   <= '0;
            rob_val_q   <= '0;
        end else begin
            cdb_ptr_q   <= cdb_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_id_q    <= cdb_id_d;
            cdb_val_q   <= cdb_val_d;
            rob_ptr_q   <= rob_ptr_d;
            rob_valid_q <= rob_valid_d;
            rob_id_q    <= rob_id_d;
            rob_flags_q <= rob_flags_d;
            rob_wbs_q   <= rob_wbs_d;
            rob_val_q   <= rob_val_d;
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_id    = cdb_id_q;
    assign cdb_val   = cdb_val_q;
    assign rob_valid = rob_valid_q;
    assign rob_id    = rob_id_q;
    assign rob_flags = rob_flags_q;
    assign rob_wbs   = rob_wbs_q;
    assign rob_val   = rob_val_q;

endmodule

// File: tb/tb_fu_result_arbiter.sv
// tb_fu_result_arbiter: directed plus randomized checks of the CDB/ROB
// round-robin arbiter against a transaction-level reference model.
module tb_fu_result_arbiter;

    localparam int N      = 4;
    localparam int ID_W   = 4;
    localparam int DATA_W = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic [N-1:0]        cdb_req;
    logic [N*ID_W-1:0]   cdb_req_id;
    logic [N*DATA_W-1:0] cdb_req_val;
    logic [N-1:0]        cdb_grant;
    logic [N-1:0]        rob_req;
    logic [N*ID_W-1:0]   rob_req_id;
    logic [N*DATA_W-1:0] rob_req_flags;
    logic [N*DATA_W-1:0] rob_req_wbs;
    logic [N*DATA_W-1:0] rob_req_val;
    logic [N-1:0]        rob_grant;
    logic                rob_ready;
    logic                flush;
    logic                cdb_valid;
    logic [ID_W-1:0]     cdb_id;
    logic [DATA_W-1:0]   cdb_val;
    logic                rob_valid;
    logic [ID_W-1:0]     rob_id;
    logic [DATA_W-1:0]   rob_flags;
    logic [DATA_W-1:0]   rob_wbs;
    logic [DATA_W-1:0]   rob_val;

    fu_result_arbiter #(.N(N), .ID_W(ID_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .cdb_req(cdb_req), .cdb_req_id(cdb_req_id), .cdb_req_val(cdb_req_val),
        .cdb_grant(cdb_grant),
        .rob_req(rob_req), .rob_req_id(rob_req_id), .rob_req_flags(rob_req_flags),
        .rob_req_wbs(rob_req_wbs), .rob_req_val(rob_req_val), .rob_grant(rob_grant),
        .rob_ready(rob_ready), .flush(flush),
        .cdb_valid(cdb_valid), .cdb_id(cdb_id), .cdb_val(cdb_val),
        .rob_valid(rob_valid), .rob_id(rob_id), .rob_flags(rob_flags),
        .rob_wbs(rob_wbs), .rob_val(rob_val)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: what each bus should show and where each pointer sits.
    int          m_cdb_ptr, m_rob_ptr;
    logic        m_cdb_valid, m_rob_valid;
    logic [31:0] m_cdb_id, m_cdb_val, m_rob_id, m_rob_flags, m_rob_wbs, m_rob_val;
    int          last_cw, last_rw;
    logic [N-1:0] g_cdb, g_rob;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cdb_ptr = 0; m_rob_ptr = 0;
        m_cdb_valid = 0; m_rob_valid = 0;
        m_cdb_id = 0; m_cdb_val = 0;
        m_rob_id = 0; m_rob_flags = 0; m_rob_wbs = 0; m_rob_val = 0;
    endtask

    // First requester in the order ptr, ptr+1, ... modulo N; -1 if none.
    function automatic int rr_winner(input logic [N-1:0] req, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (req[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic set_cdb(input int i, input logic r, input logic [31:0] id, input logic [31:0] v);
        cdb_req[i] = r;
        cdb_req_id[i*ID_W +: ID_W] = id[ID_W-1:0];
        cdb_req_val[i*DATA_W +: DATA_W] = v[DATA_W-1:0];
    endtask

    task automatic set_rob(input int i, input logic r, input logic [31:0] id, input logic [31:0] fl,
                           input logic [31:0] wb, input logic [31:0] v);
        rob_req[i] = r;
        rob_req_id[i*ID_W +: ID_W] = id[ID_W-1:0];
        rob_req_flags[i*DATA_W +: DATA_W] = fl[DATA_W-1:0];
        rob_req_wbs[i*DATA_W +: DATA_W] = wb[DATA_W-1:0];
        rob_req_val[i*DATA_W +: DATA_W] = v[DATA_W-1:0];
    endtask

    task automatic clear_reqs();
        cdb_req = '0;
        rob_req = '0;
    endtask

    // One clock cycle: inputs are already driven (posedge+1). Checks grants
    // mid-cycle, then the registered buses just after the next edge.
    task automatic cycle(input string tag);
        logic [N-1:0] ecg, erg;
        #3;
        last_cw = (rst || flush) ? -1 : rr_winner(cdb_req, m_cdb_ptr);
        last_rw = (rst || flush || !rob_ready) ? -1 : rr_winner(rob_req, m_rob_ptr);
        ecg = '0; erg = '0;
        if (last_cw >= 0) ecg[last_cw] = 1'b1;
        if (last_rw >= 0) erg[last_rw] = 1'b1;
        g_cdb = cdb_grant;
        g_rob = rob_grant;
        chk({tag, ".cdb_grant"}, 32'(cdb_grant), 32'(ecg));
        chk({tag, ".rob_grant"}, 32'(rob_grant), 32'(erg));
        @(posedge clk);
        m_cdb_valid = (last_cw >= 0);
        if (last_cw >= 0) begin
            m_cdb_id  = 32'(cdb_req_id[last_cw*ID_W +: ID_W]);
            m_cdb_val = 32'(cdb_req_val[last_cw*DATA_W +: DATA_W]);
            m_cdb_ptr = (last_cw + 1) % N;
        end
        m_rob_valid = (last_rw >= 0);
        if (last_rw >= 0) begin
            m_rob_id    = 32'(rob_req_id[last_rw*ID_W +: ID_W]);
            m_rob_flags = 32'(rob_req_flags[last_rw*DATA_W +: DATA_W]);
            m_rob_wbs   = 32'(rob_req_wbs[last_rw*DATA_W +: DATA_W]);
            m_rob_val   = 32'(rob_req_val[last_rw*DATA_W +: DATA_W]);
            m_rob_ptr   = (last_rw + 1) % N;
        end
        #1;
        chk({tag, ".cdb_valid"}, 32'(cdb_valid), 32'(m_cdb_valid));
        chk({tag, ".cdb_id"},    32'(cdb_id),    m_cdb_id);
        chk({tag, ".cdb_val"},   32'(cdb_val),   m_cdb_val);
        chk({tag, ".rob_valid"}, 32'(rob_valid), 32'(m_rob_valid));
        chk({tag, ".rob_id"},    32'(rob_id),    m_rob_id);
        chk({tag, ".rob_flags"}, 32'(rob_flags), m_rob_flags);
        chk({tag, ".rob_wbs"},   32'(rob_wbs),   m_rob_wbs);
        chk({tag, ".rob_val"},   32'(rob_val),   m_rob_val);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; rob_ready = 1'b1;
        cdb_req = '0; cdb_req_id = '0; cdb_req_val = '0;
        rob_req = '0; rob_req_id = '0; rob_req_flags = '0; rob_req_wbs = '0; rob_req_val = '0;
        model_reset();

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("reset.cdb_valid", 32'(cdb_valid), 0);
        chk("reset.rob_valid", 32'(rob_valid), 0);
        chk("reset.cdb_id", 32'(cdb_id), 0);
        chk("reset.rob_val", 32'(rob_val), 0);
        rst = 1'b0;

        // Round-robin with all four FUs requesting, id = index.
        for (int i = 0; i < N; i++) set_cdb(i, 1'b1, i, 8'h40 + i);
        for (int k = 0; k < 8; k++) begin
            cycle("rr");
            chk("rr.grant_seq", 32'(g_cdb), 32'(1) << (k % N));
            chk("rr.id_seq", 32'(cdb_id), k % N);
            chk("rr.valid", 32'(cdb_valid), 1);
        end

        // Wrap/skip: FU2 win puts pointer at 3, then 0101 -> FU0, then FU2.
        clear_reqs();
        set_cdb(2, 1'b1, 2, 8'h22);
        cycle("wrap.pre");
        set_cdb(0, 1'b1, 9, 8'h99);
        cycle("wrap.a");
        chk("wrap.fu0", 32'(g_cdb), 32'b0001);
        cycle("wrap.b");
        chk("wrap.fu2", 32'(g_cdb), 32'b0100);

        // ROB backpressure.
        clear_reqs();
        set_rob(0, 1'b1, 4'h5, 8'h20, 8'h03, 8'hA7);
        rob_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle("bp.stall");
            chk("bp.no_grant", 32'(g_rob), 0);
            chk("bp.no_valid", 32'(rob_valid), 0);
        end
        rob_ready = 1'b1;
        cycle("bp.go");
        chk("bp.grant", 32'(g_rob), 32'b0001);
        chk("bp.id", 32'(rob_id), 32'h5);
        chk("bp.flags", 32'(rob_flags), 32'h20);
        chk("bp.val", 32'(rob_val), 32'hA7);

        // Flush: cdb pointer is 3, so FU0 wins once flush drops.
        clear_reqs();
        set_cdb(0, 1'b1, 1, 8'h11);
        set_cdb(1, 1'b1, 2, 8'h12);
        flush = 1'b1;
        cycle("flush.on");
        chk("flush.no_grant", 32'(g_cdb), 0);
        chk("flush.valid", 32'(cdb_valid), 0);
        flush = 1'b0;
        cycle("flush.off");
        chk("flush.resume", 32'(g_cdb), 32'b0001);

        // Independent channels: both pointers now at 1.
        clear_reqs();
        set_cdb(1, 1'b1, 4'h7, 8'h71);
        set_rob(1, 1'b1, 4'h7, 8'h01, 8'h02, 8'h71);
        set_cdb(2, 1'b1, 4'h8, 8'h82);
        cycle("indep.a");
        chk("indep.cdb", 32'(g_cdb), 32'b0010);
        chk("indep.rob", 32'(g_rob), 32'b0010);
        cdb_req[1] = 1'b0; rob_req[1] = 1'b0;
        cycle("indep.b");
        chk("indep.next", 32'(g_cdb), 32'b0100);

        // Reset mid-transfer: cdb_valid is 1 here.
        chk("midrst.pre_valid", 32'(cdb_valid), 1);
        set_cdb(0, 1'b1, 3, 8'h33);
        set_rob(0, 1'b1, 3, 8'h33, 8'h33, 8'h33);
        rst = 1'b1;
        #1;
        chk("midrst.cdb_valid", 32'(cdb_valid), 0);
        chk("midrst.rob_valid", 32'(rob_valid), 0);
        chk("midrst.cdb_grant", 32'(cdb_grant), 0);
        chk("midrst.rob_grant", 32'(rob_grant), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_reqs();
        set_cdb(1, 1'b1, 4'hB, 8'hB1);
        set_cdb(3, 1'b1, 4'hD, 8'hD3);
        cycle("midrst.rel");
        chk("midrst.grant", 32'(g_cdb), 32'b0010);

        // Random traffic with FU hold-until-granted behaviour.
        clear_reqs();
        for (int t = 0; t < 400; t++) begin
            flush     = ($urandom_range(0, 7) == 0);
            rob_ready = ($urandom_range(0, 3) != 0);
            cycle("rand");
            for (int i = 0; i < N; i++) begin
                if ((last_cw == i) || (!cdb_req[i] && $urandom_range(0, 2) == 0))
                    set_cdb(i, $urandom_range(0, 1) == 1, $urandom, $urandom);
                if ((last_rw == i) || (!rob_req[i] && $urandom_range(0, 2) == 0))
                    set_rob(i, $urandom_range(0, 1) == 1, $urandom, $urandom, $urandom, $urandom);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fu_result_arbiter.md
Name: fu_result_arbiter

Overview:
- Shares the single CDB broadcast port and the single ROB write port among N functional units (jump FU, ALU FUs, etc.).
- Each FU's output stage raises a request and holds its payload until granted; this block picks one winner per channel per cycle, round-robin.
- It returns a one-cycle grant pulse to the winner and drives registered CDB/ROB buses one cycle later.
- Sits between the FU output stages and the CDB/ROB.

Parameters:
- N, 4, number of functional units (2..8)
- ID_W, 4, ROB id width
- DATA_W, 8, value/flags/wbs width

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous reset, active-high
- cdb_req  input  N  per-FU CDB request (FU cdb_transmit_out)
- cdb_req_id  input  N×ID_W  per-FU CDB tag
- cdb_req_val  input  N×DATA_W  per-FU CDB value
- cdb_grant  output  N  one-hot grant pulse to FU (FU cdb_transmit)
- rob_req  input  N  per-FU ROB request (FU rob_transmit_out)
- rob_req_id  input  N×ID_W  per-FU ROB id
- rob_req_flags  input  N×DATA_W  per-FU flags
- rob_req_wbs  input  N×DATA_W  per-FU writeback select
- rob_req_val  input  N×DATA_W  per-FU value
- rob_grant  output  N  one-hot grant pulse to FU (FU rob_transmit)
- rob_ready  input  1  ROB can accept a write this cycle
- flush  input  1  pipeline flush (mispredict)
- cdb_valid  output  1  CDB broadcast valid
- cdb_id  output  ID_W  broadcast tag
- cdb_val  output  DATA_W  broadcast value
- rob_valid  output  1  ROB write valid
- rob_id  output  ID_W  ROB write id
- rob_flags  output  DATA_W  ROB write flags
- rob_wbs  output  DATA_W  ROB write wbs
- rob_val  output  DATA_W  ROB write value

Behaviour:
- Clock and reset: single clock domain. rst is asynchronous and active-high.
- Reset values: all registered outputs 0; cdb_ptr = 0; rob_ptr = 0. Grants are combinational, so they are 0 while rst is high.
- Channels are independent, each with its own log2(N)-bit priority pointer.
- CDB grant (combinational, same cycle as request):
  - Winner is the first set bit of cdb_req scanning from index cdb_ptr upward, wrapping N-1 → 0.
  - cdb_grant is one-hot for the winner, zero if no request or if flush = 1.
- CDB register update (posedge):
  - If a grant was issued: cdb_valid = 1, cdb_id/cdb_val = winner's payload, cdb_ptr = (winner+1) mod N.
  - Otherwise: cdb_valid = 0, id/val hold, pointer holds.
- ROB grant: same scan over rob_req from rob_ptr. Additionally suppressed when rob_ready = 0.
- ROB register update (posedge):
  - If granted: rob_valid = 1, payload captured, rob_ptr = (winner+1) mod N.
  - Otherwise: rob_valid = 0, payload and pointer hold.
- Latency: request→grant 0 cycles; grant→bus valid 1 cycle. Back-to-back grants give one bus transfer per cycle per channel.
- Handshake: an FU keeps req and payload stable until it sees its grant. It drops or replaces them the cycle after the grant. The arbiter never grants an unrequested FU.
- Fairness: a continuously requesting FU is granted within N grants on its channel.
- One FU may win both channels in the same cycle.
- flush = 1: no grants on either channel that cycle; both valids go 0 next edge; pointers hold. Requests pending at flush re-arbitrate once flush deasserts.
- Simultaneous flush and rob_ready = 0: flush dominates; result is identical to flush alone.
- Pointer wrap: a winner of N-1 sets the pointer to 0.
- Reset mid-transfer: valids clear immediately (asynchronous); pending FU requests re-arbitrate from index 0 after rst deasserts.

Test Plan:
- Reset: rst = 1 mid-run with cdb_valid = 1 → cdb_valid, rob_valid, grants 0 immediately; after release, req = 4'b1010 → grant 4'b0010.
- Round-robin: N = 4, cdb_req = 4'b1111 held 8 cycles, payload id = index → grants 0,1,2,3,0,1,2,3; cdb_id sequence lags grants by 1 cycle; cdb_valid = 1 each cycle.
- Wrap/skip: cdb_ptr = 3 (after FU2 win), cdb_req = 4'b0101 → grant FU0, then with same req → FU2.
- ROB backpressure: rob_req = 4'b0001, rob_ready = 0 for 3 cycles → rob_grant = 0, rob_valid = 0. rob_ready = 1 → grant 4'b0001, next edge rob_valid = 1 with FU0's id/flags/wbs/val (e.g. id = 4'h5, flags = 8'h20).
- Flush: cdb_req = 4'b0011, flush = 1 one cycle → no grants, next-cycle cdb_valid = 0, pointer unchanged. flush = 0 → grant FU at pointer.
- Independent channels: FU1 requests both CDB and ROB, FU2 requests only CDB, pointers at 1 → cdb_grant = rob_grant = 4'b0010 in the same cycle. Next cycle cdb_grant = 4'b0100.
